// File: rtl/msb_priority_encoder_seq.sv
// Registered N-input MSB-first priority encoder with pending-request buffer and valid/ready output.
// Optional rotating priority is selected by defining PENC_RR_EN.
module msb_priority_encoder_seq #(
    parameter int unsigned N = 8,
    parameter int unsigned W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         ready,
    output logic [W-1:0] y,
    output logic         valid,
    output logic         pend_any
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_e;

    state_e       state_q, state_d;
    logic [N-1:0] pend_q, pend_d;
    logic [W-1:0] y_q, y_d;
    logic         pend_any_q, pend_any_d;
    logic [N-1:0] cand;
    logic [N-1:0] sel_oh;
    logic [W-1:0] sel_idx;
    logic         load;

`ifdef PENC_RR_EN
    logic [W-1:0] ptr_q, ptr_d;

    // Search ptr-1 down to 0, then wrap from N-1 down to ptr.
    function automatic logic [W-1:0] sel_rr(input logic [N-1:0] c, input logic [W-1:0] ptr);
        logic [W-1:0] s;
        logic         found;
        int unsigned  idx;
        s     = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(ptr) + N - k) % N;
            if (!found && c[idx]) begin
                s     = W'(idx);
                found = 1'b1;
            end
        end
        return s;
    endfunction
`else
    function automatic logic [W-1:0] sel_fixed(input logic [N-1:0] c);
        logic [W-1:0] s;
        s = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (c[i]) s = W'(i);
        end
        return s;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pend_q     <= '0;
            y_q        <= '0;
            pend_any_q <= 1'b0;
`ifdef PENC_RR_EN
            ptr_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            y_q        <= y_d;
            pend_any_q <= pend_any_d;
`ifdef PENC_RR_EN
            ptr_q      <= ptr_d;
`endif
        end
    end

    always_comb begin
        cand = pend_q | req;
        load = ((state_q == IDLE) || ready) && (cand != '0);
`ifdef PENC_RR_EN
        sel_idx = sel_rr(cand, ptr_q);
`else
        sel_idx = sel_fixed(cand);
`endif
        sel_oh          = '0;
        sel_oh[sel_idx] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = HOLD;
        end else if ((state_q == HOLD) && ready) begin
            state_d = IDLE;
        end
    end

    // A fresh request for a bit that was already pending and is served now
    // stays pending, so the new event gets its own later service.
    always_comb begin
        pend_d = cand;
        y_d    = y_q;
`ifdef PENC_RR_EN
        ptr_d  = ptr_q;
`endif
        if (load) begin
            pend_d = (cand & ~sel_oh) | (req & pend_q & sel_oh);
            y_d    = sel_idx;
`ifdef PENC_RR_EN
            ptr_d  = sel_idx;
`endif
        end
        pend_any_d = (pend_d != '0);
    end

    always_comb begin
        valid    = (state_q == HOLD);
        y        = y_q;
        pend_any = pend_any_q;
    end

endmodule

// File: tb/tb_msb_priority_encoder_seq.sv
// Directed scoreboard bench for msb_priority_encoder_seq with N=8.
module tb_msb_priority_encoder_seq;

    localparam int unsigned N = 8;
    localparam int unsigned W = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         ready;
    logic [W-1:0] y;
    logic         valid;
    logic         pend_any;

    int total;
    int bad;
    int exp_q[$];

    msb_priority_encoder_seq #(.N(N)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .ready    (ready),
        .y        (y),
        .valid    (valid),
        .pend_any (pend_any)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, obs, expv);
        end
    endtask

    // Apply inputs for one cycle; a transfer in this cycle is checked against the scoreboard.
    task automatic drive(input logic [N-1:0] r, input logic rd);
        int e;
        req   = r;
        ready = rd;
        if (valid === 1'b1 && rd) begin
            chk("sb_avail", 32'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("sb_y", 32'(y), 32'(e));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) begin
            if (valid !== 1'b1) break;
            drive('0, 1'b1);
        end
        chk("drain_valid", 32'(valid), 0);
        chk("drain_sb_empty", 32'(exp_q.size()), 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        req   = '0;
        ready = 1'b0;
        @(posedge clk);
        #1;
        drive(8'hFF, 1'b0);
        chk("rst_y", 32'(y), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_pend_any", 32'(pend_any), 0);
        rst_n = 1'b1;
        drive('0, 1'b0);
        chk("rst_req_discarded", 32'(valid), 0);

        // 1: burst drain
        exp_q.push_back(7); exp_q.push_back(4); exp_q.push_back(2);
        drive(8'b1001_0100, 1'b1);
        chk("s1_valid", 32'(valid), 1);
        chk("s1_first_y", 32'(y), 7);
        drive('0, 1'b1);
        drive('0, 1'b1);
        chk("s1_last_y", 32'(y), 2);
        drive('0, 1'b1);
        chk("s1_valid_end", 32'(valid), 0);
        chk("s1_pend_any_end", 32'(pend_any), 0);
        chk("s1_sb_empty", 32'(exp_q.size()), 0);

        // 2: backpressure
        exp_q.push_back(3); exp_q.push_back(1);
        drive(8'b0000_1010, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("s2_hold_y", 32'(y), 3);
            chk("s2_hold_valid", 32'(valid), 1);
            drive('0, 1'b0);
        end
        chk("s2_hold_pend_any", 32'(pend_any), 1);
        drive('0, 1'b1);
        chk("s2_second_y", 32'(y), 1);
        drive('0, 1'b1);
        chk("s2_valid_end", 32'(valid), 0);
        chk("s2_sb_empty", 32'(exp_q.size()), 0);

        // 3: re-request collision on bit 5
        exp_q.push_back(7); exp_q.push_back(5); exp_q.push_back(5);
        drive(8'h80, 1'b0);
        drive(8'h20, 1'b0);
        chk("s3_pending", 32'(pend_any), 1);
        drive(8'h20, 1'b1);
        chk("s3_first5_y", 32'(y), 5);
        chk("s3_repended", 32'(pend_any), 1);
        drive('0, 1'b1);
        chk("s3_second5_y", 32'(y), 5);
        chk("s3_pend_clear", 32'(pend_any), 0);
        drain();

        // 4: reset mid-burst, with a request during reset discarded
        drive(8'hF0, 1'b0);
        chk("s4_pre_valid", 32'(valid), 1);
        chk("s4_pre_pend", 32'(pend_any), 1);
        rst_n = 1'b0;
        drive(8'h08, 1'b0);
        chk("s4_rst_y", 32'(y), 0);
        chk("s4_rst_valid", 32'(valid), 0);
        chk("s4_rst_pend_any", 32'(pend_any), 0);
        exp_q.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive('0, 1'b1);
            chk("s4_no_stale", 32'(valid), 0);
        end

        // 5: starvation vs rotation
`ifdef PENC_RR_EN
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(7); exp_q.push_back(0);
        end
`else
        for (int i = 0; i < 6; i++) exp_q.push_back(7);
        exp_q.push_back(0);
`endif
        for (int i = 0; i < 6; i++) drive(8'b1000_0001, 1'b1);
        drain();

        // 6: idle accumulation under backpressure
        exp_q.push_back(7); exp_q.push_back(6); exp_q.push_back(2); exp_q.push_back(0);
        drive(8'h80, 1'b0);
        drive(8'h40, 1'b0);
        drive(8'h04, 1'b0);
        drive(8'h01, 1'b0);
        chk("s6_held_y", 32'(y), 7);
        drain();
        chk("s6_pend_any_end", 32'(pend_any), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
